// File: rtl/order_book_matcher.sv
// Single-pair order book: tracks best bid/ask, runs a one-cycle trade when the book crosses,
// and halts on a persistent wide spread or when the trade-count limit is reached.
module obm_side #(
  parameter int PRICE_MAX = 99,
  parameter bit IS_BID    = 1'b1
) (
  input  logic       vld,
  input  logic [7:0] px,
  input  logic       have,
  input  logic [7:0] best,
  output logic       take,
  output logic       bad
);
  localparam logic [7:0] PX_MAX = 8'(PRICE_MAX);

  logic better;

  // A bid improves upward, an ask improves downward.
  assign better = IS_BID ? (px > best) : (px < best);
  assign bad    = vld && (px > PX_MAX);
  assign take   = vld && !bad && (!have || better);
endmodule

module order_book_matcher #(
  parameter int PRICE_MAX    = 99,
  parameter int SPREAD_LIMIT = 20,
  parameter int HALT_CYCLES  = 16,
  parameter int TRADE_LIMIT  = 200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       buy_valid,
  input  logic [7:0] buy_px,
  input  logic       sell_valid,
  input  logic [7:0] sell_px,
  input  logic       halt_clr,
  output logic       order_ready,
  output logic       order_reject,
  output logic [7:0] buy_price,
  output logic [7:0] sell_price,
  output logic [7:0] spread_now,
  output logic [7:0] trade_count,
  output logic [7:0] last_trade_px,
  output logic [1:0] state,
  output logic       halt_signal,
  output logic       match_signal
);
  localparam int          NUM_SIDES = 2;  // 0 = bid, 1 = ask
  localparam logic [7:0]  SPREAD_LIM = 8'(SPREAD_LIMIT);
  localparam logic [7:0]  HALT_LAST  = 8'(HALT_CYCLES - 1);
  localparam logic [8:0]  TRADE_LIM  = 9'(TRADE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUOTE = 2'd1,
    S_MATCH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] px;
  } order_t;

  state_t                        st;
  logic [NUM_SIDES-1:0][7:0]     best;
  logic [NUM_SIDES-1:0]          have;
  logic [NUM_SIDES-1:0]          have_nxt;
  order_t [NUM_SIDES-1:0]        ord;
  logic [NUM_SIDES-1:0]          take;
  logic [NUM_SIDES-1:0]          bad;
  logic [7:0]                    wide_cnt;
  logic                          crossed;
  logic                          wide;
  logic [8:0]                    tc_inc;

  assign ord[0] = '{vld: buy_valid,  px: buy_px};
  assign ord[1] = '{vld: sell_valid, px: sell_px};

  for (genvar g = 0; g < NUM_SIDES; g++) begin : g_side
    obm_side #(
      .PRICE_MAX (PRICE_MAX),
      .IS_BID    (g == 0)
    ) u_side (
      .vld  (ord[g].vld),
      .px   (ord[g].px),
      .have (have[g]),
      .best (best[g]),
      .take (take[g]),
      .bad  (bad[g])
    );
  end

  assign have_nxt   = have | take;
  assign crossed    = &have && (best[0] >= best[1]);
  assign spread_now = (&have && (best[1] > best[0])) ? (best[1] - best[0]) : 8'd0;
  assign wide       = (spread_now > SPREAD_LIM);
  assign tc_inc     = {1'b0, trade_count} + 9'd1;

  assign buy_price    = best[0];
  assign sell_price   = best[1];
  assign state        = st;
  assign order_ready  = (st == S_IDLE) || (st == S_QUOTE);
  assign match_signal = (st == S_MATCH);
  assign halt_signal  = (st == S_HALT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st            <= S_IDLE;
      best          <= '0;
      have          <= '0;
      wide_cnt      <= 8'd0;
      trade_count   <= 8'd0;
      last_trade_px <= 8'd0;
      order_reject  <= 1'b0;
    end else begin
      order_reject <= 1'b0;
      case (st)
        S_IDLE, S_QUOTE: begin
          if (crossed) begin
            // Crossed book trades next cycle; orders this cycle are ignored outright.
            st       <= S_MATCH;
            wide_cnt <= 8'd0;
          end else begin
            for (int g = 0; g < NUM_SIDES; g++) begin
              if (take[g]) begin
                best[g] <= ord[g].px;
                have[g] <= 1'b1;
              end
            end
            order_reject <= |bad;
            if (st == S_QUOTE && wide && wide_cnt == HALT_LAST) begin
              st       <= S_HALT;
              wide_cnt <= 8'd0;
            end else begin
              wide_cnt <= (st == S_QUOTE && wide) ? wide_cnt + 8'd1 : 8'd0;
              st       <= (&have_nxt) ? S_QUOTE : S_IDLE;
            end
          end
        end
        S_MATCH: begin
          last_trade_px <= best[1];
          trade_count   <= (trade_count == 8'hFF) ? 8'hFF : trade_count + 8'd1;
          best          <= '0;
          have          <= '0;
          wide_cnt      <= 8'd0;
          st            <= (tc_inc >= TRADE_LIM) ? S_HALT : S_IDLE;
        end
        S_HALT: begin
          order_reject <= buy_valid | sell_valid;
          if (halt_clr) begin
            best        <= '0;
            have        <= '0;
            wide_cnt    <= 8'd0;
            trade_count <= 8'd0;
            st          <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_order_book_matcher.sv
// Two matcher instances (default limits and tight limits) driven by directed then random orders,
// each compared every cycle against a rule-level model of the book.
module tb_order_book_matcher;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       buy_valid = 1'b0, sell_valid = 1'b0, halt_clr = 1'b0;
  logic [7:0] buy_px = 8'd0, sell_px = 8'd0;

  logic [1:0]      o_ready, o_rej, o_halt, o_match;
  logic [1:0][7:0] o_bp, o_sp, o_spr, o_tc, o_ltp;
  logic [1:0][1:0] o_st;

  typedef struct {
    int st, bp, sp, hb, ha, wc, tc, ltp, rej;
  } mdl_t;

  mdl_t m [2];
  int   hcyc [2] = '{16, 4};
  int   tlim [2] = '{200, 2};
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  order_book_matcher u_dut (
    .clk(clk), .resetn(resetn), .buy_valid(buy_valid), .buy_px(buy_px),
    .sell_valid(sell_valid), .sell_px(sell_px), .halt_clr(halt_clr),
    .order_ready(o_ready[0]), .order_reject(o_rej[0]), .buy_price(o_bp[0]),
    .sell_price(o_sp[0]), .spread_now(o_spr[0]), .trade_count(o_tc[0]),
    .last_trade_px(o_ltp[0]), .state(o_st[0]), .halt_signal(o_halt[0]),
    .match_signal(o_match[0]));

  order_book_matcher #(.HALT_CYCLES(4), .TRADE_LIMIT(2)) u_lim (
    .clk(clk), .resetn(resetn), .buy_valid(buy_valid), .buy_px(buy_px),
    .sell_valid(sell_valid), .sell_px(sell_px), .halt_clr(halt_clr),
    .order_ready(o_ready[1]), .order_reject(o_rej[1]), .buy_price(o_bp[1]),
    .sell_price(o_sp[1]), .spread_now(o_spr[1]), .trade_count(o_tc[1]),
    .last_trade_px(o_ltp[1]), .state(o_st[1]), .halt_signal(o_halt[1]),
    .match_signal(o_match[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t x = '{default: 0};
    return x;
  endfunction

  function automatic int spr(mdl_t x);
    if (x.hb != 0 && x.ha != 0 && x.sp > x.bp) return x.sp - x.bp;
    return 0;
  endfunction

  // One clock edge of the book rules, written from the behavioural description.
  function automatic mdl_t step(mdl_t x, int hc, int tl, bit bv, int bpx, bit sv, int spx, bit clr);
    mdl_t n = x;
    bit   wide;
    n.rej = 0;
    case (x.st)
      0, 1: begin
        if (x.hb != 0 && x.ha != 0 && x.bp >= x.sp) begin
          n.st = 2; n.wc = 0;
        end else begin
          if (bv) begin
            if (bpx > 99) n.rej = 1;
            else if (x.hb == 0 || bpx > x.bp) begin n.bp = bpx; n.hb = 1; end
          end
          if (sv) begin
            if (spx > 99) n.rej = 1;
            else if (x.ha == 0 || spx < x.sp) begin n.sp = spx; n.ha = 1; end
          end
          wide = (x.st == 1) && (spr(x) > 20);
          if (wide && x.wc == hc - 1) begin
            n.st = 3; n.wc = 0;
          end else begin
            n.wc = wide ? x.wc + 1 : 0;
            n.st = (n.hb != 0 && n.ha != 0) ? 1 : 0;
          end
        end
      end
      2: begin
        n.ltp = x.sp;
        n.tc  = (x.tc == 255) ? 255 : x.tc + 1;
        n.bp = 0; n.sp = 0; n.hb = 0; n.ha = 0; n.wc = 0;
        n.st  = (x.tc + 1 >= tl) ? 3 : 0;
      end
      default: begin
        n.rej = (bv || sv) ? 1 : 0;
        if (clr) begin
          n.bp = 0; n.sp = 0; n.hb = 0; n.ha = 0; n.wc = 0; n.tc = 0; n.st = 0;
        end
      end
    endcase
    return n;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.%0d.state", tag, i), 32'(o_st[i]),  m[i].st);
      chk($sformatf("%s.%0d.bid",   tag, i), 32'(o_bp[i]),  m[i].bp);
      chk($sformatf("%s.%0d.ask",   tag, i), 32'(o_sp[i]),  m[i].sp);
      chk($sformatf("%s.%0d.spread",tag, i), 32'(o_spr[i]), spr(m[i]));
      chk($sformatf("%s.%0d.tcnt",  tag, i), 32'(o_tc[i]),  m[i].tc);
      chk($sformatf("%s.%0d.ltp",   tag, i), 32'(o_ltp[i]), m[i].ltp);
      chk($sformatf("%s.%0d.rej",   tag, i), 32'(o_rej[i]), m[i].rej);
      chk($sformatf("%s.%0d.ready", tag, i), 32'(o_ready[i]), (m[i].st < 2) ? 1 : 0);
      chk($sformatf("%s.%0d.halt",  tag, i), 32'(o_halt[i]),  (m[i].st == 3) ? 1 : 0);
      chk($sformatf("%s.%0d.match", tag, i), 32'(o_match[i]), (m[i].st == 2) ? 1 : 0);
    end
  endtask

  task automatic drive(input bit bv, input int bpx, input bit sv, input int spx, input bit clr);
    buy_valid = bv; buy_px = 8'(bpx); sell_valid = sv; sell_px = 8'(spx); halt_clr = clr;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      m[i] = step(m[i], hcyc[i], tlim[i], buy_valid, int'(buy_px), sell_valid, int'(sell_px), halt_clr);
    #1;
    check_all(tag);
    drive(0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges and check that it takes effect without a clock.
  task automatic async_reset(input string tag);
    #2 resetn = 1'b0;
    #1;
    m[0] = mdl_reset(); m[1] = mdl_reset();
    check_all(tag);
    #1 resetn = 1'b1;
  endtask

  initial begin
    m[0] = mdl_reset(); m[1] = mdl_reset();
    #12;
    check_all("reset");
    chk("reset_ready", 32'(o_ready[0]), 1);
    resetn = 1'b1;

    // Build a quote
    drive(1, 40, 0, 0, 0); tick("t1a");
    drive(0, 0, 1, 55, 0); tick("t1b");
    chk("t1_spread", 32'(o_spr[0]), 15);
    chk("t1_state",  32'(o_st[0]), 1);

    // Cross it: quote updates, then one MATCH cycle, then the cleared book
    drive(1, 60, 0, 0, 0); tick("t2a");
    tick("t2b");
    chk("t2_match", 32'(o_match[0]), 1);
    tick("t2c");
    chk("t2_ltp",   32'(o_ltp[0]), 55);
    chk("t2_tcnt",  32'(o_tc[0]), 1);
    chk("t2_state", 32'(o_st[0]), 0);

    // Out-of-range rejected, simultaneous pair accepted
    drive(1, 100, 0, 0, 0); tick("t3a");
    chk("t3_rej", 32'(o_rej[0]), 1);
    tick("t3b");
    drive(1, 30, 1, 99, 0); tick("t3c");
    chk("t3_spread", 32'(o_spr[0]), 69);

    // Second trade: the tight-limit instance halts on trade count
    drive(1, 99, 0, 0, 0); tick("t5a");
    tick("t5b");
    tick("t5c");
    chk("t5_lim_state", 32'(o_st[1]), 3);
    chk("t5_lim_tcnt",  32'(o_tc[1]), 2);
    drive(0, 0, 0, 0, 1); tick("t5d");

    // Wide spread held until the circuit breaker trips
    drive(1, 10, 1, 40, 0); tick("t4a");
    for (int k = 0; k < 15; k++) tick("t4w");
    chk("t4_pre_halt", 32'(o_st[0]), 1);
    tick("t4h");
    chk("t4_halt", 32'(o_halt[0]), 1);
    drive(1, 20, 0, 0, 0); tick("t4r");
    chk("t4_rej", 32'(o_rej[0]), 1);
    drive(0, 0, 0, 0, 1); tick("t4c");
    chk("t4_clr_tcnt", 32'(o_tc[0]), 0);

    // Mid-operation asynchronous reset with a wide book counting
    drive(1, 30, 1, 55, 0); tick("t6a");
    tick("t6b"); tick("t6c");
    async_reset("t6rst");

    // Random traffic, prices biased to cross often, rare resets
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0 ? $urandom_range(100, 255) : $urandom_range(10, 90),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0 ? $urandom_range(100, 255) : $urandom_range(10, 90),
            $urandom_range(0, 7) == 0);
      tick("rnd");
      if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
